hwacc_cm_eqc_req_issuer: RTL and testbench

Front half of the QPC-CQC-EQC context assembly path in the hardware-access context manager. It accepts a CQC cache response tagged with a request tag and writes the CQC entry into the CQC staged buffer at that tag. It then extracts the EQN from the entry and issues the EQC cache get request carrying the same tag. The downstream combiner uses that tag to read the staged buffers back. An outstanding-tag counter stops the block from overrunning staged-buffer capacity.

---
 rtl/hwacc_cm_eqc_req_issuer_if.sv | 27 ++
 rtl/hwacc_cm_eqc_req_issuer.sv | 70 +++++++
 tb/tb_hwacc_cm_eqc_req_issuer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwacc_cm_eqc_req_issuer_if.sv
// hwacc_cm_eqc_req_issuer_if: CQC response, staged-buffer write and EQC get-request bundle.
interface hwacc_cm_eqc_req_issuer_if #(
    parameter int TAG_LOG        = 5,
    parameter int CQC_WIDTH      = 256,
    parameter int ICM_ADDR_WIDTH = 64
);
    logic                              cqc_rsp_valid;
    logic [TAG_LOG-1:0]                cqc_rsp_tag;
    logic [CQC_WIDTH-1:0]              cqc_rsp_data;
    logic                              cqc_rsp_ready;
    logic                              cqc_buffer_wen;
    logic [TAG_LOG-1:0]                cqc_buffer_addr;
    logic [CQC_WIDTH-1:0]              cqc_buffer_din;
    logic                              eqc_get_req_valid;
    logic [TAG_LOG+ICM_ADDR_WIDTH-1:0] eqc_get_req_head;
    logic                              eqc_get_req_ready;
    modport master (
        input  cqc_rsp_valid, cqc_rsp_tag, cqc_rsp_data, eqc_get_req_ready,
        output cqc_rsp_ready, cqc_buffer_wen, cqc_buffer_addr, cqc_buffer_din,
               eqc_get_req_valid, eqc_get_req_head
    );
    modport slave (
        output cqc_rsp_valid, cqc_rsp_tag, cqc_rsp_data, eqc_get_req_ready,
        input  cqc_rsp_ready, cqc_buffer_wen, cqc_buffer_addr, cqc_buffer_din,
               eqc_get_req_valid, eqc_get_req_head
    );
endinterface

// File: rtl/hwacc_cm_eqc_req_issuer.sv
// hwacc_cm_eqc_req_issuer: stages a tagged CQC entry, then issues the EQC get request for its EQN.
module hwacc_cm_eqc_req_issuer #(
    parameter int                        TAG_LOG         = 5,
    parameter int                        MAX_OUTSTANDING = 32,
    parameter int                        CQC_WIDTH       = 256,
    parameter int                        EQN_LSB         = 96,
    parameter int                        EQN_WIDTH       = 8,
    parameter int                        EQC_SLOT_LOG    = 6,
    parameter int                        ICM_ADDR_WIDTH  = 64,
    parameter logic [ICM_ADDR_WIDTH-1:0] EQC_BASE        = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    hwacc_cm_eqc_req_issuer_if.master bus,
    input  logic                     tag_release,
    output logic [TAG_LOG:0]         outstanding_cnt,
    output logic                     release_underflow
);
    typedef enum logic [1:0] {IDLE, WRITE, REQ} state_t;
    localparam logic [TAG_LOG:0] MAX_CNT = (TAG_LOG+1)'(MAX_OUTSTANDING);
    state_t                    state, state_nx;
    logic [TAG_LOG-1:0]        tag_r;
    logic [CQC_WIDTH-1:0]      data_r;
    logic [ICM_ADDR_WIDTH-1:0] eqc_addr, eqn_ext;
    logic                      acc, issue;
    assign eqn_ext = ICM_ADDR_WIDTH'(data_r[EQN_LSB +: EQN_WIDTH]);
    assign acc     = bus.cqc_rsp_valid && bus.cqc_rsp_ready;
    assign issue   = bus.eqc_get_req_valid && bus.eqc_get_req_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx              = state;
        bus.cqc_rsp_ready     = (state == IDLE) && (outstanding_cnt < MAX_CNT);
        bus.cqc_buffer_wen    = state == WRITE;
        bus.cqc_buffer_addr   = bus.cqc_buffer_wen ? tag_r : '0;
        bus.cqc_buffer_din    = bus.cqc_buffer_wen ? data_r : '0;
        bus.eqc_get_req_valid = state == REQ;
        bus.eqc_get_req_head  = bus.eqc_get_req_valid ? {tag_r, eqc_addr} : '0;
        case (state)
            IDLE:    state_nx = acc ? WRITE : IDLE;
            WRITE:   state_nx = REQ;
            REQ:     state_nx = issue ? IDLE : REQ;
            default: state_nx = IDLE;
        endcase
    end
    // The address is registered in WRITE so the request head is steady for the whole REQ phase.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tag_r    <= '0;
            data_r   <= '0;
            eqc_addr <= '0;
        end else begin
            if (acc) begin
                tag_r  <= bus.cqc_rsp_tag;
                data_r <= bus.cqc_rsp_data;
            end
            if (state == WRITE) eqc_addr <= EQC_BASE + (eqn_ext << EQC_SLOT_LOG);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            outstanding_cnt   <= '0;
            release_underflow <= 1'b0;
        end else if (issue && !tag_release) begin
            outstanding_cnt <= outstanding_cnt + 1'b1;
        end else if (!issue && tag_release) begin
            if (outstanding_cnt == '0) release_underflow <= 1'b1;
            else                       outstanding_cnt   <= outstanding_cnt - 1'b1;
        end
endmodule

// File: tb/tb_hwacc_cm_eqc_req_issuer.sv
// tb_hwacc_cm_eqc_req_issuer: randomized transaction-level checks of two issuers differing only in EQC base.
module tb_hwacc_cm_eqc_req_issuer;
    localparam int TL = 5, CW = 256, AW = 64;
    localparam logic [AW-1:0] BASE_A = 64'h1000, BASE_B = 64'hFFFF_FFFF_FFFF_F000;
    logic clk = 0, rst = 1;
    logic rsp_valid = 0, req_ready = 0, tag_release = 0;
    logic [TL-1:0] rsp_tag = '0;
    logic [CW-1:0] rsp_data = '0;
    logic [TL:0] cnt_a, cnt_b;
    logic uf_a, uf_b;
    int checks = 0, errors = 0;
    int m_cnt = 0;
    bit m_uf = 0;
    time acc_time = 0;
    always #5 clk = ~clk;
    hwacc_cm_eqc_req_issuer_if #(.TAG_LOG(TL), .CQC_WIDTH(CW), .ICM_ADDR_WIDTH(AW)) bus_a ();
    hwacc_cm_eqc_req_issuer_if #(.TAG_LOG(TL), .CQC_WIDTH(CW), .ICM_ADDR_WIDTH(AW)) bus_b ();
    assign bus_a.cqc_rsp_valid = rsp_valid;
    assign bus_a.cqc_rsp_tag = rsp_tag;
    assign bus_a.cqc_rsp_data = rsp_data;
    assign bus_a.eqc_get_req_ready = req_ready;
    assign bus_b.cqc_rsp_valid = rsp_valid;
    assign bus_b.cqc_rsp_tag = rsp_tag;
    assign bus_b.cqc_rsp_data = rsp_data;
    assign bus_b.eqc_get_req_ready = req_ready;
    hwacc_cm_eqc_req_issuer #(.EQC_BASE(BASE_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .tag_release(tag_release),
        .outstanding_cnt(cnt_a), .release_underflow(uf_a));
    hwacc_cm_eqc_req_issuer #(.EQC_BASE(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .tag_release(tag_release),
        .outstanding_cnt(cnt_b), .release_underflow(uf_b));

    function automatic logic [CW-1:0] rand_data(input logic [7:0] eqn);
        logic [CW-1:0] d;
        for (int i = 0; i < CW / 32; i++) d[i*32 +: 32] = $urandom;
        d[96 +: 8] = eqn;
        return d;
    endfunction
    function automatic logic [TL+AW-1:0] exp_head(input logic [TL-1:0] t, input logic [7:0] eqn, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        a = base + 64'(eqn) * 64'd64;
        return {t, a};
    endfunction
    // Counter rules: +1 per issued request, -1 per release, saturate at 0 and flag underflow.
    task automatic apply_edge(input bit inc, input bit rel);
        if (inc && !rel) m_cnt++;
        else if (!inc && rel) begin
            if (m_cnt == 0) m_uf = 1;
            else m_cnt--;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rsp_valid = 0; req_ready = 0; tag_release = 0; rst = 1;
        @(negedge clk);
        rst = 0; m_cnt = 0; m_uf = 0;
    endtask

    task automatic send(input logic [TL-1:0] t, input logic [7:0] eqn, input int stall, input bit rel_at_hs, input int budget, output bit ok);
        logic [CW-1:0] d;
        logic [TL+AW-1:0] ha, hb;
        int w;
        d = rand_data(eqn); ha = exp_head(t, eqn, BASE_A); hb = exp_head(t, eqn, BASE_B);
        ok = 0; w = 0;
        rsp_valid = 1; rsp_tag = t; rsp_data = d;
        while (bus_a.cqc_rsp_ready !== 1'b1 && w < budget) begin
            @(negedge clk); w++;
        end
        if (bus_a.cqc_rsp_ready !== 1'b1) begin
            rsp_valid = 0;
            return;
        end
        ok = 1;
        @(posedge clk); acc_time = $time;
        @(negedge clk);
        rsp_valid = 0; rsp_tag = TL'($urandom); rsp_data = rand_data(8'h00);
        checks++;
        if ({bus_a.cqc_buffer_wen, bus_a.cqc_buffer_addr, bus_a.cqc_buffer_din, bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready} !== {1'b1, t, d, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_cycle: wen=%0b addr=%0d din=%h valid=%0b ready=%0b, want wen=1 addr=%0d din=%h valid=0 ready=0",
                     bus_a.cqc_buffer_wen, bus_a.cqc_buffer_addr, bus_a.cqc_buffer_din, bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready, t, d);
        end
        @(negedge clk);
        checks++;
        if ({bus_a.cqc_buffer_wen, bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready, bus_a.eqc_get_req_head, bus_b.eqc_get_req_head} !== {1'b0, 1'b1, 1'b0, ha, hb}) begin
            errors++;
            $display("FAIL req_issue: wen=%0b valid=%0b ready=%0b head_a=%h head_b=%h, want wen=0 valid=1 ready=0 head_a=%h head_b=%h",
                     bus_a.cqc_buffer_wen, bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready, bus_a.eqc_get_req_head, bus_b.eqc_get_req_head, ha, hb);
        end
        repeat (stall) begin
            tag_release = ($urandom_range(0, 3) == 0);
            @(posedge clk); apply_edge(0, tag_release);
            @(negedge clk); tag_release = 0;
            checks++;
            if ({bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, bus_a.cqc_rsp_ready, bus_a.cqc_buffer_wen, cnt_a, uf_a} !== {1'b1, ha, 1'b0, 1'b0, 6'(m_cnt), m_uf}) begin
                errors++;
                $display("FAIL req_hold: valid=%0b head=%h ready=%0b wen=%0b cnt=%0d uf=%0b, want valid=1 head=%h ready=0 wen=0 cnt=%0d uf=%0b",
                         bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, bus_a.cqc_rsp_ready, bus_a.cqc_buffer_wen, cnt_a, uf_a, ha, m_cnt, m_uf);
            end
        end
        req_ready = 1; tag_release = rel_at_hs;
        @(posedge clk); apply_edge(1, rel_at_hs);
        @(negedge clk); req_ready = 0; tag_release = 0;
        checks++;
        if ({bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, cnt_a, uf_a, bus_a.cqc_rsp_ready} !== {1'b0, {(TL+AW){1'b0}}, 6'(m_cnt), m_uf, m_cnt < 32}) begin
            errors++;
            $display("FAIL req_done: valid=%0b head=%h cnt=%0d uf=%0b ready=%0b, want valid=0 head=0 cnt=%0d uf=%0b ready=%0b",
                     bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, cnt_a, uf_a, bus_a.cqc_rsp_ready, m_cnt, m_uf, m_cnt < 32);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({bus_a.cqc_rsp_ready, bus_a.cqc_buffer_wen, bus_a.cqc_buffer_addr, bus_a.cqc_buffer_din, bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, cnt_a, uf_a}
            !== {1'b1, 1'b0, {TL{1'b0}}, {CW{1'b0}}, 1'b0, {(TL+AW){1'b0}}, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: ready=%0b wen=%0b addr=%0d din=%h valid=%0b head=%h cnt=%0d uf=%0b, want ready=1 and all else 0",
                     bus_a.cqc_rsp_ready, bus_a.cqc_buffer_wen, bus_a.cqc_buffer_addr, bus_a.cqc_buffer_din, bus_a.eqc_get_req_valid, bus_a.eqc_get_req_head, cnt_a, uf_a);
        end
        rst = 0; m_cnt = 0; m_uf = 0;
    endtask

    task automatic test_single();
        bit ok;
        send(5'd5, 8'h03, 0, 0, 4, ok);
        checks++;
        if (!ok || cnt_a !== 6'd1) begin
            errors++;
            $display("FAIL single: accepted=%0b cnt=%0d, want accepted=1 cnt=1", ok, cnt_a);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(TL'($urandom), 8'($urandom), 10, 0, 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_accept: accepted=0, want 1");
        end
    endtask

    task automatic test_random();
        bit ok, want;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tag_release = ($urandom_range(0, 2) == 0);
                @(posedge clk); apply_edge(0, tag_release);
                @(negedge clk); tag_release = 0;
            end
            want = m_cnt < 32;
            send(TL'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom), 3, ok);
            checks++;
            if (ok !== want) begin
                errors++;
                $display("FAIL random_accept[%0d]: accepted=%0b, want %0b (cnt model %0d)", i, ok, want, m_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        time prev;
        do_reset();
        send(5'd0, 8'h11, 0, 0, 4, ok);
        for (int i = 1; i < 6; i++) begin
            prev = acc_time;
            send(TL'(i), 8'($urandom), 0, 0, 4, ok);
            checks++;
            if (!ok || acc_time - prev !== 30) begin
                errors++;
                $display("FAIL back_to_back[%0d]: accepted=%0b spacing=%0t, want accepted=1 spacing=30", i, ok, acc_time - prev);
            end
        end
    endtask

    task automatic test_capacity();
        bit ok;
        do_reset();
        for (int i = 0; i < 32; i++) send(TL'(i), 8'($urandom), 0, 0, 4, ok);
        send(5'd7, 8'h22, 0, 0, 5, ok);
        checks++;
        if (ok || cnt_a !== 6'd32 || bus_a.cqc_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL capacity_block: accepted=%0b cnt=%0d ready=%0b, want accepted=0 cnt=32 ready=0", ok, cnt_a, bus_a.cqc_rsp_ready);
        end
        tag_release = 1;
        @(posedge clk); apply_edge(0, 1);
        @(negedge clk); tag_release = 0;
        checks++;
        if (bus_a.cqc_rsp_ready !== 1'b1 || cnt_a !== 6'd31) begin
            errors++;
            $display("FAIL capacity_release: ready=%0b cnt=%0d, want ready=1 cnt=31", bus_a.cqc_rsp_ready, cnt_a);
        end
        send(5'd7, 8'h22, 0, 0, 0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL capacity_reaccept: accepted=0, want 1");
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        for (int i = 0; i < 7; i++) send(TL'(i), 8'($urandom), 0, 0, 4, ok);
        send(5'd9, 8'h40, 1, 1, 4, ok);
        checks++;
        if (cnt_a !== 6'(m_cnt) || (m_cnt == 7 && cnt_a !== 6'd7)) begin
            errors++;
            $display("FAIL simultaneous: cnt=%0d, want %0d", cnt_a, m_cnt);
        end
    endtask

    task automatic test_underflow();
        bit ok;
        do_reset();
        tag_release = 1;
        @(posedge clk); apply_edge(0, 1);
        @(negedge clk); tag_release = 0;
        checks++;
        if (cnt_a !== 6'd0 || uf_a !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: cnt=%0d uf=%0b, want cnt=0 uf=1", cnt_a, uf_a);
        end
        send(5'd3, 8'h01, 0, 0, 4, ok);
        checks++;
        if (uf_a !== 1'b1 || cnt_a !== 6'd1) begin
            errors++;
            $display("FAIL underflow_sticky: uf=%0b cnt=%0d, want uf=1 cnt=1", uf_a, cnt_a);
        end
        do_reset();
        checks++;
        if (uf_a !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: uf=%0b, want 0", uf_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [TL+AW-1:0] hb;
        bit ok;
        do_reset();
        send(5'd2, 8'h05, 0, 0, 4, ok);
        hb = exp_head(5'd17, 8'hFF, BASE_B);
        rsp_valid = 1; rsp_tag = 5'd17; rsp_data = rand_data(8'hFF);
        @(posedge clk);
        @(negedge clk); rsp_valid = 0;
        @(negedge clk);
        checks++;
        if (bus_b.eqc_get_req_valid !== 1'b1 || bus_b.eqc_get_req_head !== hb) begin
            errors++;
            $display("FAIL wrap_addr: valid=%0b head=%h, want valid=1 head=%h", bus_b.eqc_get_req_valid, bus_b.eqc_get_req_head, hb);
        end
        #2 rst = 1;
        @(negedge clk);
        checks++;
        if (bus_a.eqc_get_req_valid !== 1'b0 || bus_a.cqc_rsp_ready !== 1'b1 || cnt_a !== 6'd0) begin
            errors++;
            $display("FAIL reset_in_req: valid=%0b ready=%0b cnt=%0d, want valid=0 ready=1 cnt=0", bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready, cnt_a);
        end
        rst = 0; m_cnt = 0; m_uf = 0;
        rsp_valid = 1; rsp_tag = 5'd4; rsp_data = rand_data(8'h10);
        @(posedge clk);
        @(negedge clk); rsp_valid = 0;
        #1 rst = 1;
        #1;
        checks++;
        if (bus_a.cqc_buffer_wen !== 1'b0 || bus_a.cqc_buffer_addr !== '0 || bus_a.cqc_buffer_din !== '0) begin
            errors++;
            $display("FAIL reset_in_write: wen=%0b addr=%0d, want wen=0 addr=0 din=0", bus_a.cqc_buffer_wen, bus_a.cqc_buffer_addr);
        end
        @(negedge clk); rst = 0;
        @(negedge clk);
        checks++;
        if (bus_a.cqc_buffer_wen !== 1'b0 || bus_a.eqc_get_req_valid !== 1'b0 || bus_a.cqc_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_write_after: wen=%0b valid=%0b ready=%0b, want 0 0 1", bus_a.cqc_buffer_wen, bus_a.eqc_get_req_valid, bus_a.cqc_rsp_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_capacity();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
